sd_data_xfer_ctrl: RTL and testbench
====================================

Name: sd_data_xfer_ctrl

Overview:
- Sequences single- and multi-block SD data transfers over the 4-bit DAT data PHY.
- Issues per-block start/abort codes on the PHY start_dat bus and checks the write CRC status token.
- Waits out card busy on DAT0 after writes, counts blocks, and enforces read and busy timeouts.
- Sits between the host register block (command/status) and the data PHY.

Parameters:
- BLKCNT_W, 16: width of the block count and blocks-done counter.
- TMO_W, 16: width of the timeout value and timeout counter.
- START_LIM, 4: maximum cycles to wait for the PHY to leave IDLE after a start code.

Ports:
- sd_clk  in  1  SD-side clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_write_i  in  1  one-cycle pulse; starts a write transfer.
- cmd_read_i  in  1  one-cycle pulse; starts a read transfer.
- abort_i  in  1  one-cycle pulse; aborts the active transfer.
- blk_count_i  in  BLKCNT_W  number of blocks; sampled at command accept.
- timeout_i  in  TMO_W  timeout in sd_clk cycles; sampled at accept; 0 disables the timeout.
- start_dat_o  out  2  PHY command: 00 none, 01 write, 10 read, 11 abort.
- phy_busy_i  in  1  high while the PHY is not in IDLE.
- crc_tok_valid_i  in  1  one-cycle strobe; CRC status token from the PHY is valid.
- crc_tok_i  in  3  CRC status token; 3'b010 means accepted.
- dat0_i  in  1  DAT0 line; low means the card is busy.
- ready_o  out  1  high in IDLE only.
- xfer_active_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at transfer end.
- err_crc_o  out  1  sticky: bad CRC token or token missing.
- err_tmo_o  out  1  sticky: timeout.
- err_abort_o  out  1  sticky: aborted (abort_i or START_LIM exceeded).
- blocks_done_o  out  BLKCNT_W  blocks completed successfully.

Behaviour:
- Reset values:
  - start_dat_o=00, done_o=0, all err_* =0, blocks_done_o=0.
  - ready_o=1, xfer_active_o=0, state=IDLE.
- States: IDLE, START, XFER, CHK, BUSY, NEXT, ABORT, DONE.
- IDLE:
  - Exactly one of cmd_write_i/cmd_read_i high → latch direction, blk_count_i and timeout_i.
  - On accept: clear all err_* and blocks_done_o.
  - blk_count_i==0 → go to DONE (no PHY activity); otherwise go to START.
  - Both commands high in the same cycle → ignored.
  - Commands outside IDLE → ignored.
- START:
  - Drive start_dat_o=01 (write) or 10 (read) every cycle.
  - phy_busy_i=1 → start_dat_o=00 next cycle, clear the timeout counter, go to XFER.
  - After START_LIM cycles without phy_busy_i → set err_abort_o, go to ABORT.
- XFER:
  - start_dat_o=00.
  - Timeout counter increments each cycle (reads only). Reaching timeout_i (nonzero) → set err_tmo_o, go to ABORT.
  - Any crc_tok_valid_i strobe during XFER is latched.
  - phy_busy_i=0 → read: go to NEXT; write: go to CHK.
- CHK (1 cycle):
  - Token latched and ==3'b010 → clear the timeout counter, go to BUSY.
  - Otherwise → set err_crc_o, go to DONE. No abort is needed because the PHY is already idle.
- BUSY:
  - Wait for dat0_i==1, sampled high for 2 consecutive cycles, then go to NEXT.
  - Timeout counter runs; reaching timeout_i (nonzero) → set err_tmo_o, go to DONE.
- NEXT (1 cycle):
  - blocks_done_o+1.
  - New count == latched count → DONE; otherwise → START.
  - Counter wraps modulo 2^BLKCNT_W; the comparison uses the latched count.
- ABORT:
  - Drive start_dat_o=11 for exactly 1 cycle, then 00.
  - Wait for phy_busy_i=0, then go to DONE. This wait has no timeout.
- DONE: done_o=1 for one cycle, then IDLE. Error flags hold until the next accepted command.
- abort_i:
  - In START, XFER or BUSY: set err_abort_o, go to ABORT. Takes priority over all other transitions that cycle.
  - In CHK, NEXT, ABORT, DONE or IDLE: ignored.
- Timeout counter saturates at its maximum value; it does not wrap.
- Reset mid-transfer: immediate return to reset values. No abort code is driven; the PHY is reset by the same rst.

Test Plan:
- Read, blk_count=3, timeout=0, PHY model busy 1100 cycles per block → start_dat_o=10 three times, blocks_done_o=3, done_o pulses once, no errors.
- Write, blk_count=2, tokens 010, dat0 low 50 cycles after each block → two 01 starts, blocks_done_o=2, no errors.
- Write, token 101 on block 1 of 4 → err_crc_o=1, blocks_done_o=0, done_o pulses, no second start code.
- Read, timeout=200, PHY stays busy → err_tmo_o at cycle 200 of XFER, one cycle of 11, done_o after phy_busy_i falls.
- abort_i mid-XFER of block 2 (write) → start_dat_o=11 for one cycle, err_abort_o=1, blocks_done_o=1.
- blk_count=0 → done_o 2 cycles after the command, start_dat_o stays 00. Simultaneous cmd_write_i+cmd_read_i → ignored, ready_o stays 1.

Source files
------------

// File: rtl/sd_data_xfer_ctrl_if.sv
// Host/PHY-facing signal bundle for the SD data transfer controller.
// The slave modport is the controller's view; master is the environment's view.
interface sd_data_xfer_ctrl_if #(
    parameter int BLKCNT_W = 16,
    parameter int TMO_W    = 16
) ();
    logic                cmd_write_i;
    logic                cmd_read_i;
    logic                abort_i;
    logic [BLKCNT_W-1:0] blk_count_i;
    logic [TMO_W-1:0]    timeout_i;
    logic [1:0]          start_dat_o;
    logic                phy_busy_i;
    logic                crc_tok_valid_i;
    logic [2:0]          crc_tok_i;
    logic                dat0_i;
    logic                ready_o;
    logic                xfer_active_o;
    logic                done_o;
    logic                err_crc_o;
    logic                err_tmo_o;
    logic                err_abort_o;
    logic [BLKCNT_W-1:0] blocks_done_o;

    modport slave (
        input  cmd_write_i, cmd_read_i, abort_i, blk_count_i, timeout_i,
        input  phy_busy_i, crc_tok_valid_i, crc_tok_i, dat0_i,
        output start_dat_o, ready_o, xfer_active_o, done_o,
        output err_crc_o, err_tmo_o, err_abort_o, blocks_done_o
    );

    modport master (
        output cmd_write_i, cmd_read_i, abort_i, blk_count_i, timeout_i,
        output phy_busy_i, crc_tok_valid_i, crc_tok_i, dat0_i,
        input  start_dat_o, ready_o, xfer_active_o, done_o,
        input  err_crc_o, err_tmo_o, err_abort_o, blocks_done_o
    );
endinterface

// File: rtl/sd_data_xfer_ctrl.sv
// SD data transfer sequencer: issues per-block PHY start/abort codes, checks the
// write CRC status token, waits out DAT0 busy, counts blocks and enforces timeouts.
module sd_data_xfer_ctrl #(
    parameter int BLKCNT_W  = 16,
    parameter int TMO_W     = 16,
    parameter int START_LIM = 4
) (
    input logic                sd_clk,
    input logic                rst,
    sd_data_xfer_ctrl_if.slave bus
);
    localparam int SC_W = (START_LIM < 2) ? 1 : $clog2(START_LIM);
    localparam logic [TMO_W-1:0]    TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [BLKCNT_W-1:0] BLK_ONE = {{(BLKCNT_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]     SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]     SC_LAST = SC_W'(START_LIM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_XFER  = 3'd2,
        S_CHK   = 3'd3,
        S_BUSY  = 3'd4,
        S_NEXT  = 3'd5,
        S_ABORT = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_dir_wr;
    logic [BLKCNT_W-1:0] r_blk_cnt;
    logic [BLKCNT_W-1:0] r_blocks;
    logic [TMO_W-1:0]    r_tmo;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [SC_W-1:0]     r_start_cnt;
    logic                r_tok_seen;
    logic [2:0]          r_tok;
    logic                r_dat0_hi;
    logic [1:0]          r_start_dat;
    logic                r_ready;
    logic                r_active;
    logic                r_done;
    logic                r_err_crc;
    logic                r_err_tmo;
    logic                r_err_abt;

    logic                w_cmd_wr;
    logic                w_cmd_rd;
    logic                w_accept;
    logic                w_dir_wr;
    logic                w_set_crc;
    logic                w_set_tmo;
    logic                w_set_abt;
    logic                w_tmo_hit;
    logic [TMO_W-1:0]    w_tmo_inc;
    logic [BLKCNT_W-1:0] w_blk_inc;

    assign w_cmd_wr  = bus.cmd_write_i & ~bus.cmd_read_i;
    assign w_cmd_rd  = bus.cmd_read_i & ~bus.cmd_write_i;
    assign w_dir_wr  = w_accept ? w_cmd_wr : r_dir_wr;
    // Saturating increment; a hit is the cycle whose increment reaches the limit.
    assign w_tmo_inc = (r_tmo_cnt == {TMO_W{1'b1}}) ? r_tmo_cnt : r_tmo_cnt + TMO_ONE;
    assign w_tmo_hit = (r_tmo != {TMO_W{1'b0}}) && (w_tmo_inc == r_tmo);
    assign w_blk_inc = r_blocks + BLK_ONE;

    // State register
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and error-set strobes; abort_i wins in START/XFER/BUSY
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_set_crc = 1'b0;
        w_set_tmo = 1'b0;
        w_set_abt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_wr || w_cmd_rd) begin
                    w_accept = 1'b1;
                    if (bus.blk_count_i == {BLKCNT_W{1'b0}}) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_START;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (bus.abort_i) begin
                    w_set_abt = 1'b1;
                    w_next    = S_ABORT;
                end else if (bus.phy_busy_i) begin
                    w_next = S_XFER;
                end else if (r_start_cnt == SC_LAST) begin
                    w_set_abt = 1'b1;
                    w_next    = S_ABORT;
                end else begin
                    w_next = S_START;
                end
            end
            S_XFER: begin
                if (bus.abort_i) begin
                    w_set_abt = 1'b1;
                    w_next    = S_ABORT;
                end else if (!r_dir_wr && w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_ABORT;
                end else if (!bus.phy_busy_i) begin
                    w_next = r_dir_wr ? S_CHK : S_NEXT;
                end else begin
                    w_next = S_XFER;
                end
            end
            S_CHK: begin
                if (r_tok_seen && (r_tok == 3'b010)) begin
                    w_next = S_BUSY;
                end else begin
                    w_set_crc = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_BUSY: begin
                if (bus.abort_i) begin
                    w_set_abt = 1'b1;
                    w_next    = S_ABORT;
                end else if (bus.dat0_i && r_dat0_hi) begin
                    w_next = S_NEXT;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_next = S_BUSY;
                end
            end
            S_NEXT: begin
                if (w_blk_inc == r_blk_cnt) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_START;
                end
            end
            S_ABORT: begin
                if (!bus.phy_busy_i) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ABORT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer context, counters, token latch and sticky error flags
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_dir_wr    <= 1'b0;
            r_blk_cnt   <= {BLKCNT_W{1'b0}};
            r_blocks    <= {BLKCNT_W{1'b0}};
            r_tmo       <= {TMO_W{1'b0}};
            r_tmo_cnt   <= {TMO_W{1'b0}};
            r_start_cnt <= {SC_W{1'b0}};
            r_tok_seen  <= 1'b0;
            r_tok       <= 3'b000;
            r_dat0_hi   <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_abt   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dir_wr  <= w_cmd_wr;
                r_blk_cnt <= bus.blk_count_i;
                r_tmo     <= bus.timeout_i;
                r_blocks  <= {BLKCNT_W{1'b0}};
                r_err_crc <= 1'b0;
                r_err_tmo <= 1'b0;
                r_err_abt <= 1'b0;
            end else begin
                if (w_set_crc) r_err_crc <= 1'b1;
                if (w_set_tmo) r_err_tmo <= 1'b1;
                if (w_set_abt) r_err_abt <= 1'b1;
                if (r_state == S_NEXT) r_blocks <= w_blk_inc;
            end
            r_start_cnt <= (r_state == S_START) ? r_start_cnt + SC_ONE : {SC_W{1'b0}};
            // Counting only in read XFER and BUSY clears it on entry from START/CHK.
            if (((r_state == S_XFER) && !r_dir_wr) || (r_state == S_BUSY)) begin
                r_tmo_cnt <= w_tmo_inc;
            end else begin
                r_tmo_cnt <= {TMO_W{1'b0}};
            end
            if (r_state == S_START) begin
                r_tok_seen <= 1'b0;
            end else if ((r_state == S_XFER) && bus.crc_tok_valid_i) begin
                r_tok_seen <= 1'b1;
                r_tok      <= bus.crc_tok_i;
            end
            r_dat0_hi <= (r_state == S_BUSY) && bus.dat0_i;
        end
    end

    // Registered outputs, aligned with the state being entered
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_start_dat <= 2'b00;
            r_ready     <= 1'b1;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_next == S_START) begin
                r_start_dat <= w_dir_wr ? 2'b01 : 2'b10;
            end else if ((w_next == S_ABORT) && (r_state != S_ABORT)) begin
                r_start_dat <= 2'b11;
            end else begin
                r_start_dat <= 2'b00;
            end
            r_ready  <= (w_next == S_IDLE);
            r_active <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
        end
    end

    assign bus.start_dat_o   = r_start_dat;
    assign bus.ready_o       = r_ready;
    assign bus.xfer_active_o = r_active;
    assign bus.done_o        = r_done;
    assign bus.err_crc_o     = r_err_crc;
    assign bus.err_tmo_o     = r_err_tmo;
    assign bus.err_abort_o   = r_err_abt;
    assign bus.blocks_done_o = r_blocks;
endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Scoreboard bench for sd_data_xfer_ctrl: a behavioural PHY/card model reacts to
// start codes; expected transfer outcomes are queued and checked on each done_o.
module tb_sd_data_xfer_ctrl;
    logic sd_clk = 1'b0;
    logic rst;
    always #5 sd_clk = ~sd_clk;

    sd_data_xfer_ctrl_if bus ();
    sd_data_xfer_ctrl dut (.sd_clk(sd_clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [15:0] blocks;
        logic        crc;
        logic        tmo;
        logic        abt;
        logic [7:0]  wr_st;
        logic [7:0]  rd_st;
        logic [7:0]  ab_cyc;
        logic [15:0] gap;
    } exp_t;

    exp_t exp_q[$];
    int   tot = 0;
    int   bad = 0;

    // PHY/card model configuration, written only by the stimulus process
    int         cfg_busy_len = 10;
    int         cfg_dat0_low = 10;
    bit         cfg_stuck    = 1'b0;
    bit         cfg_deaf     = 1'b0;
    logic [2:0] tok_tab [0:7];

    task automatic check(input string name, input int act, input int expv);
        tot++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    task automatic push(input int blocks, input bit crc, input bit tmo, input bit abt,
                        input int wr_st, input int rd_st, input int ab_cyc, input int gap);
        exp_t e;
        e.blocks = 16'(blocks);
        e.crc    = crc;
        e.tmo    = tmo;
        e.abt    = abt;
        e.wr_st  = 8'(wr_st);
        e.rd_st  = 8'(rd_st);
        e.ab_cyc = 8'(ab_cyc);
        e.gap    = 16'(gap);
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic rd, input int blk, input int tmo);
        @(negedge sd_clk);
        bus.cmd_write_i = wr;
        bus.cmd_read_i  = rd;
        bus.blk_count_i = 16'(blk);
        bus.timeout_i   = 16'(tmo);
        @(negedge sd_clk);
        bus.cmd_write_i = 1'b0;
        bus.cmd_read_i  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int waited);
        waited = 0;
        while (!bus.done_o && waited < bound) begin
            @(negedge sd_clk);
            waited++;
        end
        check("done_seen", int'(bus.done_o), 1);
    endtask

    // PHY and card model: busy per block, CRC token and DAT0 busy after writes
    initial begin : phy_model
        int rem;
        int d0;
        int blk;
        bit wr;
        bit abt;
        rem = 0; d0 = 0; blk = 0; wr = 1'b0; abt = 1'b0;
        bus.phy_busy_i      = 1'b0;
        bus.crc_tok_valid_i = 1'b0;
        bus.crc_tok_i       = 3'b000;
        bus.dat0_i          = 1'b1;
        forever begin
            @(negedge sd_clk);
            bus.crc_tok_valid_i = 1'b0;
            if (d0 > 0) begin
                d0--;
                if (d0 == 0) bus.dat0_i = 1'b1;
            end
            if (rst || bus.ready_o) blk = 0;
            if (rst) begin
                bus.phy_busy_i = 1'b0;
                bus.dat0_i     = 1'b1;
                d0             = 0;
            end else if (!bus.phy_busy_i) begin
                if (!cfg_deaf && (bus.start_dat_o == 2'b01 || bus.start_dat_o == 2'b10)) begin
                    bus.phy_busy_i = 1'b1;
                    wr  = (bus.start_dat_o == 2'b01);
                    rem = cfg_busy_len;
                    abt = 1'b0;
                end
            end else if (bus.start_dat_o == 2'b11 && !abt) begin
                abt = 1'b1;
                rem = 3;
            end else if (cfg_stuck && !abt) begin
                rem = rem;
            end else if (rem > 1) begin
                rem--;
            end else begin
                bus.phy_busy_i = 1'b0;
                if (wr && !abt) begin
                    bus.crc_tok_valid_i = 1'b1;
                    bus.crc_tok_i       = tok_tab[blk % 8];
                    bus.dat0_i          = 1'b0;
                    d0                  = cfg_dat0_low;
                end
                blk++;
            end
        end
    end

    // Monitor: tallies PHY codes per transfer and scores each done_o pulse
    initial begin : monitor
        logic [1:0] prev;
        int   cyc, wr_st, rd_st, ab_cyc, xfer_cyc, gap;
        exp_t e;
        prev = 2'b00; cyc = 0; wr_st = 0; rd_st = 0; ab_cyc = 0; xfer_cyc = 0; gap = 0;
        forever begin
            @(negedge sd_clk);
            cyc++;
            if (rst) begin
                prev = 2'b00; wr_st = 0; rd_st = 0; ab_cyc = 0; gap = 0;
            end else begin
                if (bus.start_dat_o == 2'b01 && prev != 2'b01) wr_st++;
                if (bus.start_dat_o == 2'b10 && prev != 2'b10) rd_st++;
                if (bus.start_dat_o == 2'b11) ab_cyc++;
                if (prev == 2'b10 && bus.start_dat_o == 2'b00) xfer_cyc = cyc;
                if (prev != 2'b11 && bus.start_dat_o == 2'b11) gap = cyc - xfer_cyc;
                prev = bus.start_dat_o;
                if (bus.done_o) begin
                    check("exp_available", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("blocks_done", int'(bus.blocks_done_o), int'(e.blocks));
                        check("err_crc", int'(bus.err_crc_o), int'(e.crc));
                        check("err_tmo", int'(bus.err_tmo_o), int'(e.tmo));
                        check("err_abort", int'(bus.err_abort_o), int'(e.abt));
                        check("write_starts", wr_st, int'(e.wr_st));
                        check("read_starts", rd_st, int'(e.rd_st));
                        check("abort_cycles", ab_cyc, int'(e.ab_cyc));
                        if (e.gap != 16'd0) check("tmo_gap", gap, int'(e.gap));
                    end
                    wr_st = 0; rd_st = 0; ab_cyc = 0; gap = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        for (int i = 0; i < 8; i++) tok_tab[i] = 3'b010;
        rst = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_read_i  = 1'b0;
        bus.abort_i     = 1'b0;
        bus.blk_count_i = 16'd0;
        bus.timeout_i   = 16'd0;
        repeat (4) @(negedge sd_clk);
        check("rst_ready", int'(bus.ready_o), 1);
        check("rst_active", int'(bus.xfer_active_o), 0);
        check("rst_start_dat", int'(bus.start_dat_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_err", int'({bus.err_crc_o, bus.err_tmo_o, bus.err_abort_o}), 0);
        check("rst_blocks", int'(bus.blocks_done_o), 0);
        rst = 1'b0;
        @(negedge sd_clk);

        // Three-block read, slow PHY
        cfg_busy_len = 1100;
        push(3, 1'b0, 1'b0, 1'b0, 0, 3, 0, 0);
        issue(1'b0, 1'b1, 3, 0);
        wait_done(4000, w);
        @(negedge sd_clk);

        // Two-block write; a stray read command mid-transfer must be ignored
        cfg_busy_len = 40;
        cfg_dat0_low = 50;
        push(2, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0);
        issue(1'b1, 1'b0, 2, 0);
        repeat (30) @(negedge sd_clk);
        bus.cmd_read_i = 1'b1;
        @(negedge sd_clk);
        bus.cmd_read_i = 1'b0;
        wait_done(1000, w);
        @(negedge sd_clk);

        // Bad CRC token on the first of four write blocks
        tok_tab[0] = 3'b101;
        push(0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        issue(1'b1, 1'b0, 4, 0);
        wait_done(500, w);
        tok_tab[0] = 3'b010;
        @(negedge sd_clk);

        // Read timeout of 200 with the PHY stuck busy
        cfg_stuck = 1'b1;
        push(0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 200);
        issue(1'b0, 1'b1, 1, 200);
        wait_done(600, w);
        check("busy_low_at_done", int'(bus.phy_busy_i), 0);
        cfg_stuck = 1'b0;
        @(negedge sd_clk);

        // abort_i during the second block of a write
        cfg_busy_len = 100;
        cfg_dat0_low = 20;
        push(1, 1'b0, 1'b0, 1'b1, 2, 0, 1, 0);
        issue(1'b1, 1'b0, 3, 0);
        w = 0;
        while (bus.blocks_done_o != 16'd1 && w < 1000) begin
            @(negedge sd_clk);
            w++;
        end
        check("blk1_reached", int'(bus.blocks_done_o), 1);
        w = 0;
        while (!bus.phy_busy_i && w < 50) begin
            @(negedge sd_clk);
            w++;
        end
        check("blk2_started", int'(bus.phy_busy_i), 1);
        repeat (10) @(negedge sd_clk);
        bus.abort_i = 1'b1;
        @(negedge sd_clk);
        bus.abort_i = 1'b0;
        wait_done(200, w);
        @(negedge sd_clk);

        // PHY never leaves IDLE: start limit forces an abort
        cfg_deaf = 1'b1;
        push(0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0);
        issue(1'b0, 1'b1, 2, 0);
        wait_done(50, w);
        cfg_deaf = 1'b0;
        @(negedge sd_clk);

        // Zero-block command completes without PHY activity
        push(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        issue(1'b1, 1'b0, 0, 0);
        wait_done(5, w);
        check("blk0_latency_ok", int'(w <= 1), 1);
        @(negedge sd_clk);

        // Simultaneous read and write commands are ignored
        issue(1'b1, 1'b1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            check("both_ready", int'(bus.ready_o), 1);
            check("both_active", int'(bus.xfer_active_o), 0);
            check("both_start_dat", int'(bus.start_dat_o), 0);
            @(negedge sd_clk);
        end

        repeat (5) @(negedge sd_clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
